// File: rtl/control_sequencer_if.sv
// Bundle between the instruction sequencer and the datapath it steers.
// Latency: none (wires only). Backpressure: none here; memory wait is mem_ready.
// Ports: run/mem_ready/ir flow into the sequencer; strobes, ALU op and
//        register-file selects flow out. master = sequencer, slave = datapath side.
interface control_sequencer_if;
    // sequencer inputs
    logic        run;
    logic        mem_ready;
    logic [31:0] ir;

    // datapath strobes
    logic        pc_out;
    logic        zlo_out;
    logic        zhi_out;
    logic        mdr_out;
    logic        mar_enable;
    logic        z_enable;
    logic        lo_enable;
    logic        hi_enable;
    logic        pc_enable;
    logic        mdr_enable;
    logic        read;
    logic        ir_enable;
    logic        y_enable;
    logic        pc_increment;

    // ALU and register file control
    logic [4:0]  op_code;
    logic        rf_in;
    logic        rf_out;
    logic [3:0]  rf_in_sel;
    logic [3:0]  rf_out_sel;

    // status
    logic        busy;
    logic        illegal;

    modport master (
        input  run, mem_ready, ir,
        output pc_out, zlo_out, zhi_out, mdr_out, mar_enable, z_enable,
               lo_enable, hi_enable, pc_enable, mdr_enable, read, ir_enable,
               y_enable, pc_increment, op_code, rf_in, rf_out, rf_in_sel,
               rf_out_sel, busy, illegal
    );

    modport slave (
        output run, mem_ready, ir,
        input  pc_out, zlo_out, zhi_out, mdr_out, mar_enable, z_enable,
               lo_enable, hi_enable, pc_enable, mdr_enable, read, ir_enable,
               y_enable, pc_increment, op_code, rf_in, rf_out, rf_in_sel,
               rf_out_sel, busy, illegal
    );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetch (T0-T2) then execute (T3-T5[/T6]) one instruction.
// Latency: 6 cycles per ALU instruction with no memory wait, 7 for mul/div, +1 per stall cycle.
// Backpressure: T1 holds while mem_ready=0; run=0 parks the sequencer in IDLE between instructions.
// Ports: clk, clr (async active-low reset, synchronously released), bus (control_sequencer_if.master).
// Option: define CTRL_MULDIV_EN to add the mul/div (opcodes 15/16) LO/HI write-back through T6;
//         without it those opcodes are illegal and zhi_out/lo_enable/hi_enable are tied low.
module control_sequencer (
    input  logic                       clk,
    input  logic                       clr,
    control_sequencer_if.master        bus
);

    typedef enum logic [2:0] {
        IDLE, T0, T1, T2, T3, T4, T5
`ifdef CTRL_MULDIV_EN
        , T6
`endif
    } state_t;

    // Every state-decoded output is registered from the next-state decode so
    // the outputs track the registered state with no decode glitches.
    typedef struct packed {
        logic       busy, illegal, pc_out, zlo_out, mdr_out, mar_enable, z_enable;
        logic       read, ir_enable, y_enable, pc_increment, rf_in, rf_out;
`ifdef CTRL_MULDIV_EN
        logic       zhi_out, lo_enable, hi_enable;
`endif
        logic [4:0] op_code;
        logic [3:0] rf_in_sel;
        logic [3:0] rf_out_sel;
    } strb_t;

    // Reset: assert asynchronously, release through two flops so the first
    // state change never lands on the edge that releases reset.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    // Instruction fields
    logic [4:0] opc;
    logic [3:0] ra, rb, rc;
    logic       ir_unused;

    assign opc       = bus.ir[31:27];
    assign ra        = bus.ir[26:23];
    assign rb        = bus.ir[22:19];
    assign rc        = bus.ir[18:15];
    assign ir_unused = ^bus.ir[14:0];

    function automatic logic is_legal(input logic [4:0] op);
        logic legal;
        legal = ((op >= 5'd3) && (op <= 5'd11)) || (op == 5'd17) || (op == 5'd18);
`ifdef CTRL_MULDIV_EN
        legal = legal || (op == 5'd15) || (op == 5'd16);
`endif
        return legal;
    endfunction

`ifdef CTRL_MULDIV_EN
    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == 5'd15) || (op == 5'd16);
    endfunction
`endif

    // neg/not are unary: operand comes from rb in T4 and Y is never loaded.
    logic unary;
    assign unary = (opc == 5'd17) || (opc == 5'd18);

    state_t state_q, state_d;
    strb_t  out_q, out_d;
    state_t end_state;

    // Instruction-boundary decision; run is only looked at here and in IDLE.
    assign end_state = bus.run ? T0 : IDLE;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.run ? T0 : IDLE;
            T0:      state_d = T1;
            T1:      state_d = bus.mem_ready ? T2 : T1;
            T2:      state_d = T3;
            // out_q.illegal is only ever high in T3: the illegal pulse ends the instruction
            T3:      state_d = out_q.illegal ? end_state : T4;
            T4:      state_d = T5;
`ifdef CTRL_MULDIV_EN
            T5:      state_d = is_muldiv(opc) ? T6 : end_state;
            T6:      state_d = end_state;
`else
            T5:      state_d = end_state;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_d      = '0;
        out_d.busy = (state_d != IDLE);
        case (state_d)
            T0: begin
                out_d.pc_out       = 1'b1;
                out_d.mar_enable   = 1'b1;
                out_d.pc_increment = 1'b1;
                out_d.z_enable     = 1'b1;
            end
            T1: begin
                out_d.read = 1'b1;
            end
            T2: begin
                out_d.mdr_out   = 1'b1;
                out_d.ir_enable = 1'b1;
            end
            T3: begin
                // Decoded while still in T2, i.e. on the opcode seen at the end of T2.
                if (!is_legal(opc)) begin
                    out_d.illegal = 1'b1;
                end else if (!unary) begin
                    out_d.rf_out     = 1'b1;
                    out_d.rf_out_sel = rb;
                    out_d.y_enable   = 1'b1;
                end
            end
            T4: begin
                out_d.z_enable   = 1'b1;
                out_d.op_code    = opc;
                out_d.rf_out     = 1'b1;
                out_d.rf_out_sel = unary ? rb : rc;
            end
            T5: begin
                out_d.zlo_out = 1'b1;
`ifdef CTRL_MULDIV_EN
                if (is_muldiv(opc)) begin
                    out_d.lo_enable = 1'b1;
                end else begin
                    out_d.rf_in     = 1'b1;
                    out_d.rf_in_sel = ra;
                end
`else
                out_d.rf_in     = 1'b1;
                out_d.rf_in_sel = ra;
`endif
            end
`ifdef CTRL_MULDIV_EN
            T6: begin
                out_d.zhi_out   = 1'b1;
                out_d.hi_enable = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    // The memory-accept strobes can only fire in the cycle mem_ready is seen,
    // so they are qualified live by mem_ready while the registered state is T1.
    logic t1_accept;
    assign t1_accept = (state_q == T1) && bus.mem_ready;

    assign bus.busy         = out_q.busy;
    assign bus.illegal      = out_q.illegal;
    assign bus.pc_out       = out_q.pc_out;
    assign bus.zlo_out      = out_q.zlo_out | t1_accept;
    assign bus.mdr_out      = out_q.mdr_out;
    assign bus.mar_enable   = out_q.mar_enable;
    assign bus.z_enable     = out_q.z_enable;
    assign bus.pc_enable    = t1_accept;
    assign bus.mdr_enable   = t1_accept;
    assign bus.read         = out_q.read;
    assign bus.ir_enable    = out_q.ir_enable;
    assign bus.y_enable     = out_q.y_enable;
    assign bus.pc_increment = out_q.pc_increment;
    assign bus.rf_in        = out_q.rf_in;
    assign bus.rf_out       = out_q.rf_out;
    assign bus.op_code      = out_q.op_code;
    assign bus.rf_in_sel    = out_q.rf_in_sel;
    assign bus.rf_out_sel   = out_q.rf_out_sel;
`ifdef CTRL_MULDIV_EN
    assign bus.zhi_out      = out_q.zhi_out;
    assign bus.lo_enable    = out_q.lo_enable;
    assign bus.hi_enable    = out_q.hi_enable;
`else
    assign bus.zhi_out      = 1'b0;
    assign bus.lo_enable    = 1'b0;
    assign bus.hi_enable    = 1'b0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: randomized instruction stream against a per-instruction
// expected-cycle list, plus directed reset-during-execution scenarios.
module tb_control_sequencer;

`ifdef CTRL_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    localparam logic [31:0] ROL = 32'h48918000;

    logic clk = 1'b0;
    logic clr = 1'b0;

    control_sequencer_if bus ();

    control_sequencer dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy, illegal, pc_out, zlo_out, zhi_out, mdr_out, mar_enable, z_enable;
        logic       lo_enable, hi_enable, pc_enable, mdr_enable, read, ir_enable, y_enable;
        logic       pc_increment, rf_in, rf_out;
        logic [4:0] op_code;
        logic [3:0] rf_in_sel;
        logic [3:0] rf_out_sel;
    } obs_t;

    typedef struct {
        logic        run;
        logic        mr;
        logic [31:0] ir;
        obs_t        exp;
    } step_t;

    step_t stim[$];
    obs_t  mseq[$];
    bit    idle_now = 1'b1;
    int    errors = 0;
    int    checks = 0;
    int    legal_tab[$] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 15, 16, 17, 18};

    function automatic obs_t sample();
        obs_t o;
        o.busy = bus.busy;             o.illegal = bus.illegal;
        o.pc_out = bus.pc_out;         o.zlo_out = bus.zlo_out;
        o.zhi_out = bus.zhi_out;       o.mdr_out = bus.mdr_out;
        o.mar_enable = bus.mar_enable; o.z_enable = bus.z_enable;
        o.lo_enable = bus.lo_enable;   o.hi_enable = bus.hi_enable;
        o.pc_enable = bus.pc_enable;   o.mdr_enable = bus.mdr_enable;
        o.read = bus.read;             o.ir_enable = bus.ir_enable;
        o.y_enable = bus.y_enable;     o.pc_increment = bus.pc_increment;
        o.rf_in = bus.rf_in;           o.rf_out = bus.rf_out;
        o.op_code = bus.op_code;       o.rf_in_sel = bus.rf_in_sel;
        o.rf_out_sel = bus.rf_out_sel;
        return o;
    endfunction

    task automatic check(input string tag, input obs_t act, input obs_t exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, act, exp);
        end
    endtask

    // Expected outputs, cycle by cycle, for one instruction from T0 to its last state.
    task automatic model_seq(input logic [31:0] ir_v, input int stalls);
        obs_t        c;
        logic [4:0]  opc;
        bit          legal, unary, md;
        opc   = ir_v[31:27];
        unary = (opc == 5'd17) || (opc == 5'd18);
        md    = MD && ((opc == 5'd15) || (opc == 5'd16));
        legal = ((opc >= 5'd3) && (opc <= 5'd11)) || unary || md;
        mseq.delete();
        c = '0; c.busy = 1; c.pc_out = 1; c.mar_enable = 1; c.pc_increment = 1; c.z_enable = 1;
        mseq.push_back(c);
        for (int i = 0; i <= stalls; i++) begin
            c = '0; c.busy = 1; c.read = 1;
            if (i == stalls) begin c.mdr_enable = 1; c.zlo_out = 1; c.pc_enable = 1; end
            mseq.push_back(c);
        end
        c = '0; c.busy = 1; c.mdr_out = 1; c.ir_enable = 1;
        mseq.push_back(c);
        c = '0; c.busy = 1;
        if (!legal) begin
            c.illegal = 1;
            mseq.push_back(c);
        end else begin
            if (!unary) begin c.rf_out = 1; c.rf_out_sel = ir_v[22:19]; c.y_enable = 1; end
            mseq.push_back(c);
            c = '0; c.busy = 1; c.z_enable = 1; c.op_code = opc; c.rf_out = 1;
            c.rf_out_sel = unary ? ir_v[22:19] : ir_v[18:15];
            mseq.push_back(c);
            c = '0; c.busy = 1; c.zlo_out = 1;
            if (md) c.lo_enable = 1;
            else begin c.rf_in = 1; c.rf_in_sel = ir_v[26:23]; end
            mseq.push_back(c);
            if (md) begin
                c = '0; c.busy = 1; c.zhi_out = 1; c.hi_enable = 1;
                mseq.push_back(c);
            end
        end
    endtask

    task automatic push_step(input logic run, input logic mr, input logic [31:0] ir_v, input obs_t exp);
        step_t s;
        s.run = run; s.mr = mr; s.ir = ir_v; s.exp = exp;
        stim.push_back(s);
    endtask

    // Queue one instruction. run is random except where it is decisive (IDLE and
    // the last cycle); mem_ready is random except in T1.
    task automatic gen_instr(input logic [31:0] ir_v, input int stalls, input bit cont);
        int n;
        if (idle_now) push_step(1'b1, 1'($urandom_range(0, 1)), ir_v, '0);
        model_seq(ir_v, stalls);
        n = mseq.size();
        for (int j = 0; j < n; j++) begin
            push_step((j == n - 1) ? cont : 1'($urandom_range(0, 1)),
                      mseq[j].read ? mseq[j].mdr_enable : 1'($urandom_range(0, 1)),
                      ir_v, mseq[j]);
        end
        if (!cont) begin
            n = $urandom_range(0, 2);
            for (int j = 0; j < n; j++) push_step(1'b0, 1'($urandom_range(0, 1)), ir_v, '0);
        end
        idle_now = !cont;
    endtask

    task automatic drain();
        bus.run = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (12) @(negedge clk);
        check("drain_idle", sample(), '0);
    endtask

    // Start ROL from IDLE, run idx+1 cycles, then pulse clr and expect a clean restart at T0.
    task automatic clr_test(input int stalls, input int idx);
        obs_t o;
        model_seq(ROL, stalls);
        bus.run = 1'b1;
        bus.mem_ready = (stalls == 0);
        bus.ir = ROL;
        for (int i = 0; i <= idx; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("clr_pre_%0d_%0d", stalls, i), sample(), mseq[i]);
        end
        #1 clr = 1'b0;
        #1 check($sformatf("clr_async_%0d", stalls), sample(), '0);
        @(posedge clk);
        #1 clr = 1'b1;
        o = sample();
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            o = sample();
            if (o.busy) break;
            check($sformatf("clr_idle_%0d", stalls), o, '0);
        end
        check($sformatf("clr_restart_t0_%0d", stalls), o, mseq[0]);
        drain();
    endtask

    initial begin
        logic [31:0] ir_v;
        logic [4:0]  opc;
        bus.run = 1'b0;
        bus.mem_ready = 1'b0;
        bus.ir = '0;

        // Reset state
        repeat (2) begin
            @(negedge clk);
            check("reset_state", sample(), '0);
        end
        clr = 1'b1;

        // Idle while the reset release settles
        for (int i = 0; i < 3; i++) push_step(1'b0, 1'b0, '0, '0);

        // Directed: rol, rol with 3 stalls, mul, not, neg, illegal opcodes, run dropped mid-instruction
        gen_instr(ROL, 0, 1);
        gen_instr(ROL, 3, 1);
        gen_instr(32'h78918000, 0, 1);
        gen_instr(32'h90900000, 1, 1);
        gen_instr(32'h88A00000, 0, 0);
        gen_instr(32'h00000000, 0, 1);
        gen_instr(32'h60918000, 2, 1);
        gen_instr(32'hF8000000, 0, 1);
        gen_instr(ROL, 2, 0);

        // Random stream
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) != 0) opc = 5'(legal_tab[$urandom_range(0, legal_tab.size() - 1)]);
            else opc = 5'($urandom_range(0, 31));
            ir_v = {opc, 27'($urandom)};
            gen_instr(ir_v, $urandom_range(0, 3), (k == 59) ? 1'b0 : 1'($urandom_range(0, 3) != 0));
        end
        push_step(1'b0, 1'b0, '0, '0);

        foreach (stim[k]) begin
            @(posedge clk);
            #1;
            bus.run = stim[k].run;
            bus.mem_ready = stim[k].mr;
            bus.ir = stim[k].ir;
            @(negedge clk);
            check($sformatf("seq_cyc%0d", k), sample(), stim[k].exp);
        end

        // clr during T4, then during a T1 stall
        clr_test(0, 4);
        clr_test(3, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and clr as elsewhere in the codebase.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 clr  input  1  asynchronous active-low reset.
REQ-004 run  input  1  level; 1 permits fetch from IDLE and back-to-back instructions.
REQ-005 mem_ready  input  1  memory read-data valid; sampled in T1.
REQ-006 ir  input  32  IR contents: opcode ir[31:27], ra ir[26:23], rb ir[22:19], rc ir[18:15].
REQ-007 Datapath strobes, each an output of width 1: pc_out, zlo_out, zhi_out, mdr_out, mar_enable, z_enable, lo_enable, hi_enable, pc_enable, mdr_enable, read, ir_enable, y_enable, pc_increment.
REQ-008 op_code  output  5  ALU operation.
REQ-009 rf_in, rf_out  output  1 each  register-file write strobe and bus-drive strobe.
REQ-010 rf_in_sel, rf_out_sel  output  4 each  register index for rf_in and rf_out.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 illegal  output  1  one-cycle pulse on an unsupported opcode.

Function
REQ-013 States SHALL be IDLE, T0, T1, T2, T3, T4, T5 and T6, with one clock cycle per state except where REQ-016 stalls T1.
REQ-014 All strobes SHALL be Moore outputs decoded from the registered state, and every strobe not listed for a state SHALL be 0 in that state.
REQ-015 IDLE SHALL move to T0 when run=1 and hold otherwise. T0 SHALL assert pc_out, mar_enable, pc_increment and z_enable.
REQ-016 T1 SHALL assert read and hold while mem_ready=0. In the cycle mem_ready=1 it SHALL also assert mdr_enable, zlo_out and pc_enable, then go to T2.
REQ-017 T2 SHALL assert mdr_out and ir_enable.
REQ-018 T3 SHALL assert rf_out with rf_out_sel=rb and y_enable. For neg and not (17, 18) T3 SHALL drive no strobes.
REQ-019 T4 SHALL assert z_enable and op_code=ir[31:27], and SHALL assert rf_out with rf_out_sel=rc (rb for neg/not). op_code SHALL be 0 outside T4.
REQ-020 T5 SHALL assert zlo_out, then either rf_in with rf_in_sel=ra, or lo_enable for mul/div (15, 16).
REQ-021 T6 (mul/div only) SHALL assert zhi_out and hi_enable.
REQ-022 After the last state of an instruction (T5, or T6 for mul/div) the next state SHALL be T0 if run=1, else IDLE.
REQ-023 Supported opcodes SHALL be 3-11, 17 and 18, plus 15-16 per REQ-029.
REQ-024 An unsupported opcode seen at the end of T2 SHALL pulse illegal in T3 with no other strobes, then follow REQ-022.
REQ-025 Dropping run mid-instruction SHALL NOT abort the instruction. It only takes effect at the REQ-022 decision.
REQ-026 Decode in T3-T6 SHALL use the IR value present at the time; ir is stable after T2.

Reset
REQ-027 clr=0 SHALL force state IDLE and all outputs 0 immediately, including during a T1 stall. Release SHALL be synchronous to clk, and the first state change SHALL occur no earlier than the first rising edge after release.

Configuration
REQ-028 The macro CTRL_MULDIV_EN SHALL control mul/div support.
REQ-029 With CTRL_MULDIV_EN defined, opcodes 15 and 16 SHALL use the T5/T6 LO/HI sequence. Without it, T6 and its decode SHALL be absent, opcodes 15 and 16 SHALL be illegal per REQ-024, and hi_enable, lo_enable and zhi_out SHALL be tied 0.

Verification
REQ-030 run=1, mem_ready=1, ir=0x48918000 (rol r1,r2,r3) -> T0..T5 in 6 cycles; T4 op_code=9; T5 rf_in=1, rf_in_sel=1; T3 rf_out_sel=2; T4 rf_out_sel=3.
REQ-031 Same ir, mem_ready low for 3 cycles in T1 -> read held 4 cycles; mdr_enable and pc_enable high only in the 4th; total 9 cycles.
REQ-032 ir=0x78918000 (mul) with CTRL_MULDIV_EN -> T5 lo_enable=1, T6 zhi_out=1 and hi_enable=1; without the macro -> illegal pulse in T3, rf_in never 1, returns to T0.
REQ-033 ir=0x90900000 (not r1,r2) -> T3 all strobes 0; T4 rf_out_sel=2, op_code=18, y_enable never 1.
REQ-034 clr pulsed low during T4 -> all outputs 0 within the same cycle, busy=0; after release with run=1 the next state is T0.
REQ-035 run dropped in T2 -> instruction completes through T5, then IDLE with busy=0.
